// File: rtl/mem_port_arbiter.sv
// IF/LSU arbiter for a single-port memory; one transaction outstanding, LSU priority with IF anti-starvation.
// Best case: request in IDLE, grant next cycle, valid on rvalid; stalls hold requesters. Watchdog: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_ip,
  input  logic                if_req_ip,
  input  logic [ADDR_W-1:0]   if_addr_ip,
  output logic [DATA_W-1:0]   if_rdata_op,
  output logic                if_valid_op,
  output logic                if_stall_op,
  input  logic                lsu_req_ip,
  input  logic                lsu_we_ip,
  input  logic [DATA_W/8-1:0] lsu_be_ip,
  input  logic [ADDR_W-1:0]   lsu_addr_ip,
  input  logic [DATA_W-1:0]   lsu_wdata_ip,
  output logic [DATA_W-1:0]   lsu_rdata_op,
  output logic                lsu_valid_op,
  output logic                lsu_stall_op,
  output logic                mem_req_op,
  output logic                mem_we_op,
  output logic [DATA_W/8-1:0] mem_be_op,
  output logic [ADDR_W-1:0]   mem_addr_op,
  output logic [DATA_W-1:0]   mem_wdata_op,
  input  logic                mem_gnt_ip,
  input  logic                mem_rvalid_ip,
  input  logic [DATA_W-1:0]   mem_rdata_ip,
  output logic                bus_err_op
);
  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state;
  logic                owner_lsu;
  logic                discard;
  logic [SW-1:0]       starve_cnt;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                lsu_win;
  logic                done;
  logic                tmo;
  logic                finish;
  logic [DATA_W-1:0]   resp_data;

  // IF only beats the LSU once it has lost STARVE_LIMIT arbitrations in a row
  assign lsu_win = lsu_req_ip & ~(if_req_ip & (starve_cnt == STARVE_MAX));
  assign done    = (state == RESP) & mem_rvalid_ip;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         wait_cnt <= '0;
    else if (state == IDLE || finish)  wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + 1'b1;
  end

  // a genuine response in the same cycle wins over the watchdog
  assign tmo       = (state != IDLE) & ~done & (wait_cnt == WAIT_LAST);
  assign resp_data = tmo ? DATA_W'(32'hDEADBEEF) : mem_rdata_ip;
`else
  // watchdog not built: the comparison is constant false for any legal limit
  assign tmo       = (TIMEOUT_CYCLES < 0);
  assign resp_data = mem_rdata_ip;
`endif

  assign finish       = done | tmo;
  assign if_valid_op  = finish & ~owner_lsu & ~discard;
  assign lsu_valid_op = finish & owner_lsu;
  assign if_rdata_op  = if_valid_op  ? resp_data : '0;
  assign lsu_rdata_op = lsu_valid_op ? resp_data : '0;
  assign if_stall_op  = if_req_ip  & ~if_valid_op;
  assign lsu_stall_op = lsu_req_ip & ~lsu_valid_op;
  assign bus_err_op   = tmo;

  assign mem_req_op   = (state == REQ);
  assign mem_we_op    = we_q;
  assign mem_be_op    = be_q;
  assign mem_addr_op  = addr_q;
  assign mem_wdata_op = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_lsu  <= 1'b0;
      discard    <= 1'b0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req_ip | lsu_req_ip) begin
            owner_lsu <= lsu_win;
            state     <= REQ;
            if (lsu_win) begin
              we_q    <= lsu_we_ip;
              be_q    <= lsu_be_ip;
              addr_q  <= lsu_addr_ip;
              wdata_q <= lsu_wdata_ip;
            end else begin
              we_q    <= 1'b0;
              be_q    <= '1;
              addr_q  <= if_addr_ip;
              wdata_q <= '0;
            end
            if (lsu_win & if_req_ip)
              starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 1'b1;
            else
              starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        REQ: begin
          if (flush_ip & ~owner_lsu) discard <= 1'b1;
          if (tmo) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (mem_gnt_ip) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (flush_ip & ~owner_lsu) discard <= 1'b1;
          if (finish) begin
            state   <= IDLE;
            discard <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed literal checks of the arbiter, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush_ip;
  logic        if_req_ip;
  logic [31:0] if_addr_ip;
  logic [31:0] if_rdata_op;
  logic        if_valid_op;
  logic        if_stall_op;
  logic        lsu_req_ip;
  logic        lsu_we_ip;
  logic [3:0]  lsu_be_ip;
  logic [31:0] lsu_addr_ip;
  logic [31:0] lsu_wdata_ip;
  logic [31:0] lsu_rdata_op;
  logic        lsu_valid_op;
  logic        lsu_stall_op;
  logic        mem_req_op;
  logic        mem_we_op;
  logic [3:0]  mem_be_op;
  logic [31:0] mem_addr_op;
  logic [31:0] mem_wdata_op;
  logic        mem_gnt_ip;
  logic        mem_rvalid_ip;
  logic [31:0] mem_rdata_ip;
  logic        bus_err_op;

  int total = 0;
  int bad   = 0;

  // model state: ph 0 = no transaction, 1 = waiting for grant, 2 = waiting for response
  int          ph, gw, rw, starve;
  bit          disc, t_lsu, if_act, lsu_act, fin, e_ifv, e_lsv, lw;
  logic [31:0] if_a, l_a, l_wd, t_a, t_wd;
  logic        l_we, t_we;
  logic [3:0]  l_be, t_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .flush_ip(flush_ip),
    .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip), .if_rdata_op(if_rdata_op),
    .if_valid_op(if_valid_op), .if_stall_op(if_stall_op),
    .lsu_req_ip(lsu_req_ip), .lsu_we_ip(lsu_we_ip), .lsu_be_ip(lsu_be_ip),
    .lsu_addr_ip(lsu_addr_ip), .lsu_wdata_ip(lsu_wdata_ip), .lsu_rdata_op(lsu_rdata_op),
    .lsu_valid_op(lsu_valid_op), .lsu_stall_op(lsu_stall_op),
    .mem_req_op(mem_req_op), .mem_we_op(mem_we_op), .mem_be_op(mem_be_op),
    .mem_addr_op(mem_addr_op), .mem_wdata_op(mem_wdata_op), .mem_gnt_ip(mem_gnt_ip),
    .mem_rvalid_ip(mem_rvalid_ip), .mem_rdata_ip(mem_rdata_ip), .bus_err_op(bus_err_op)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    flush_ip = 0; if_req_ip = 0; if_addr_ip = 0;
    lsu_req_ip = 0; lsu_we_ip = 0; lsu_be_ip = 0; lsu_addr_ip = 0; lsu_wdata_ip = 0;
    mem_gnt_ip = 0; mem_rvalid_ip = 0; mem_rdata_ip = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req_op, 0);
    chk("rst_mem_addr", mem_addr_op, 0);
    chk("rst_mem_we_be", {mem_we_op, mem_be_op}, 0);
    chk("rst_mem_wdata", mem_wdata_op, 0);
    chk("rst_valids", {if_valid_op, lsu_valid_op, bus_err_op}, 0);
    reset = 1'b0;

    // IF alone: grant in cycle 1, data in cycle 2
    @(negedge clk); if_req_ip = 1; if_addr_ip = 32'h100; #1;
    chk("t1_c0_stall", if_stall_op, 1);
    chk("t1_c0_req", mem_req_op, 0);
    @(negedge clk); mem_gnt_ip = 1; #1;
    chk("t1_c1_req", mem_req_op, 1);
    chk("t1_c1_addr", mem_addr_op, 32'h100);
    chk("t1_c1_we_be", {mem_we_op, mem_be_op}, 5'b0_1111);
    chk("t1_c1_stall", if_stall_op, 1);
    @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h00500093; #1;
    chk("t1_c2_valid", if_valid_op, 1);
    chk("t1_c2_rdata", if_rdata_op, 32'h00500093);
    chk("t1_c2_stall", if_stall_op, 0);
    chk("t1_c2_lsu_valid", lsu_valid_op, 0);
    @(negedge clk); if_req_ip = 0; mem_rvalid_ip = 0; #1;
    chk("t1_c3_valid", if_valid_op, 0);
    chk("t1_c3_req", mem_req_op, 0);

    // both request: LSU load goes first
    @(negedge clk);
    if_req_ip = 1; if_addr_ip = 32'h300;
    lsu_req_ip = 1; lsu_we_ip = 0; lsu_be_ip = 4'hF; lsu_addr_ip = 32'h2000;
    @(negedge clk); mem_gnt_ip = 1; #1;
    chk("t2_lsu_first_addr", mem_addr_op, 32'h2000);
    chk("t2_lsu_first_we", mem_we_op, 0);
    @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h11112222; #1;
    chk("t2_lsu_valid", lsu_valid_op, 1);
    chk("t2_lsu_rdata", lsu_rdata_op, 32'h11112222);
    chk("t2_if_held", {if_valid_op, if_stall_op}, 2'b01);
    @(negedge clk); mem_rvalid_ip = 0; lsu_req_ip = 0; #1;
    chk("t2_idle_gap", mem_req_op, 0);
    @(negedge clk); mem_gnt_ip = 1; #1;
    chk("t2_if_addr", mem_addr_op, 32'h300);
    @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h33334444; #1;
    chk("t2_if_valid", if_valid_op, 1);
    chk("t2_if_rdata", if_rdata_op, 32'h33334444);
    @(negedge clk); mem_rvalid_ip = 0; if_req_ip = 0;

    // starvation: four LSU wins with IF pending, then IF
    @(negedge clk);
    lsu_req_ip = 1; lsu_addr_ip = 32'h3000; if_req_ip = 1; if_addr_ip = 32'h500;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); mem_gnt_ip = 1; #1;
      chk("t3_winner_addr", mem_addr_op, (k < 4) ? 32'h3000 : 32'h500);
      @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = k; #1;
      chk("t3_valid_owner", {if_valid_op, lsu_valid_op}, (k < 4) ? 2'b01 : 2'b10);
      @(negedge clk); mem_rvalid_ip = 0;
    end
    if_req_ip = 0; lsu_req_ip = 0;

    // flush during IF response: result dropped, refetch served
    @(negedge clk); if_req_ip = 1; if_addr_ip = 32'h400;
    @(negedge clk); mem_gnt_ip = 1;
    @(negedge clk); mem_gnt_ip = 0; flush_ip = 1; #1;
    chk("t4_resp_wait", if_valid_op, 0);
    @(negedge clk); flush_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'hBAD0BAD0; #1;
    chk("t4_discard_valid", if_valid_op, 0);
    chk("t4_discard_stall", if_stall_op, 1);
    chk("t4_discard_rdata", if_rdata_op, 0);
    @(negedge clk); mem_rvalid_ip = 0; #1;
    chk("t4_idle", mem_req_op, 0);
    @(negedge clk); mem_gnt_ip = 1; #1;
    chk("t4_refetch", {mem_req_op, mem_addr_op}, {1'b1, 32'h400});
    @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h13; #1;
    chk("t4_refetch_valid", {if_valid_op, if_rdata_op}, {1'b1, 32'h13});
    @(negedge clk); mem_rvalid_ip = 0; if_req_ip = 0;

    // store held until a late grant
    @(negedge clk);
    lsu_req_ip = 1; lsu_we_ip = 1; lsu_be_ip = 4'b0011; lsu_addr_ip = 32'h2004; lsu_wdata_ip = 32'hCAFEBABE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_gnt_ip = (k == 2); #1;
      chk("t5_store_ctl", {mem_req_op, mem_we_op, mem_be_op}, 6'b1_1_0011);
      chk("t5_store_addr", mem_addr_op, 32'h2004);
      chk("t5_store_wdata", mem_wdata_op, 32'hCAFEBABE);
    end
    @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 0; #1;
    chk("t5_store_ack", {lsu_valid_op, lsu_stall_op}, 2'b10);
    @(negedge clk); mem_rvalid_ip = 0; lsu_req_ip = 0; lsu_we_ip = 0;

    // grant never comes
    @(negedge clk); lsu_req_ip = 1; lsu_be_ip = 4'hF; lsu_addr_ip = 32'h2008;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      chk("t6_bus_err", bus_err_op, k == 8);
      chk("t6_lsu_valid", lsu_valid_op, k == 8);
      if (k == 8) chk("t6_deadbeef", lsu_rdata_op, 32'hDEADBEEF);
    end
    @(negedge clk); lsu_req_ip = 0; #1;
    chk("t6_back_idle", {mem_req_op, bus_err_op}, 0);
`else
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      chk("t6_hold_req", {mem_req_op, bus_err_op, lsu_valid_op}, 3'b100);
    end
    @(negedge clk); mem_gnt_ip = 1;
    @(negedge clk); mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h5; #1;
    chk("t6_late_done", {lsu_valid_op, lsu_rdata_op}, {1'b1, 32'h5});
    @(negedge clk); mem_rvalid_ip = 0; lsu_req_ip = 0;
`endif

    // reset mid-transaction: abandoned, no pulse
    @(negedge clk); if_req_ip = 1; if_addr_ip = 32'h600;
    @(negedge clk); mem_gnt_ip = 1;
    @(negedge clk); mem_gnt_ip = 0; reset = 1; #1;
    chk("t7_rst_req", mem_req_op, 0);
    @(negedge clk); reset = 0; if_req_ip = 0; mem_rvalid_ip = 1; #1;
    chk("t7_no_pulse", {if_valid_op, lsu_valid_op}, 0);
    @(negedge clk); mem_rvalid_ip = 0;

    // randomized traffic against the transaction model
    ph = 0; gw = 0; rw = 0; starve = 0; disc = 0; if_act = 0; lsu_act = 0;
    if_a = 0; l_a = 0; l_wd = 0; l_we = 0; l_be = 0;
    t_lsu = 0; t_a = 0; t_wd = 0; t_we = 0; t_be = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = $urandom & 32'hFFFF_FFFC;
      end
      flush_ip = ($urandom_range(0, 7) == 0);
      if (flush_ip) if_a = $urandom & 32'hFFFF_FFFC;
      if (!lsu_act && $urandom_range(0, 1) == 0) begin
        lsu_act = 1; l_a = $urandom; l_wd = $urandom;
        l_we = 1'($urandom_range(0, 1)); l_be = 4'($urandom_range(0, 15));
      end
      if_req_ip = if_act; if_addr_ip = if_a;
      lsu_req_ip = lsu_act; lsu_we_ip = l_we; lsu_be_ip = l_be;
      lsu_addr_ip = l_a; lsu_wdata_ip = l_wd;
      mem_gnt_ip = 0; mem_rvalid_ip = 0; mem_rdata_ip = $urandom;
      if (ph == 1) begin
        mem_gnt_ip = (gw >= 2) || ($urandom_range(0, 1) == 1);
        mem_rvalid_ip = ($urandom_range(0, 3) == 0);
      end else if (ph == 2) begin
        mem_rvalid_ip = (rw >= 2) || ($urandom_range(0, 1) == 1);
      end
      #1;
      fin   = (ph == 2) && mem_rvalid_ip;
      e_ifv = fin && !t_lsu && !disc;
      e_lsv = fin && t_lsu;
      chk("r_mem_req", mem_req_op, ph == 1);
      if (ph == 1) begin
        chk("r_mem_addr", mem_addr_op, t_a);
        chk("r_mem_ctl", {mem_we_op, mem_be_op}, {t_we, t_be});
        chk("r_mem_wdata", mem_wdata_op, t_wd);
      end
      chk("r_valids", {if_valid_op, lsu_valid_op, bus_err_op}, {e_ifv, e_lsv, 1'b0});
      chk("r_if_rdata", if_rdata_op, e_ifv ? mem_rdata_ip : 32'h0);
      chk("r_lsu_rdata", lsu_rdata_op, e_lsv ? mem_rdata_ip : 32'h0);
      chk("r_stalls", {if_stall_op, lsu_stall_op}, {if_act && !e_ifv, lsu_act && !e_lsv});
      @(posedge clk);
      if (ph == 0) begin
        if (if_act || lsu_act) begin
          lw = lsu_act && !(if_act && starve >= 4);
          starve = (lw && if_act) ? ((starve < 4) ? starve + 1 : 4) : 0;
          t_lsu = lw;
          t_a   = lw ? l_a  : if_a;
          t_we  = lw ? l_we : 1'b0;
          t_be  = lw ? l_be : 4'hF;
          t_wd  = lw ? l_wd : 32'h0;
          ph = 1; gw = 0;
        end else begin
          starve = 0;
        end
      end else if (ph == 1) begin
        if (flush_ip && !t_lsu) disc = 1;
        if (mem_gnt_ip) begin ph = 2; rw = 0; end
        else gw++;
      end else begin
        if (flush_ip && !t_lsu) disc = 1;
        if (mem_rvalid_ip) begin
          if (t_lsu) lsu_act = 0;
          else if (!disc) if_act = 0;
          disc = 0; ph = 0;
        end else rw++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the IF stage fetch port and the LSU stage load/store port.
- Arbitrates requests and sequences each transaction through a request/grant/response handshake; one transaction is outstanding at a time.
- Returns read data to the owning requester.
- Generates per-stage stall outputs that the pipeline combines with its hazard stalls.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4: number of consecutive LSU grants with IF pending, after which IF is forced to win the next arbitration.
- TIMEOUT_CYCLES, 64: watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush_ip  input  1  pipeline flush; discards the in-flight IF result.
- if_req_ip  input  1  fetch request; held stable by IF while stalled.
- if_addr_ip  input  ADDR_W  fetch address.
- if_rdata_op  output  DATA_W  fetched instruction.
- if_valid_op  output  1  fetch data valid, one-cycle pulse.
- if_stall_op  output  1  IF must hold.
- lsu_req_ip  input  1  load/store request; held stable while stalled.
- lsu_we_ip  input  1  1 = store.
- lsu_be_ip  input  DATA_W/8  byte enables.
- lsu_addr_ip  input  ADDR_W  data address.
- lsu_wdata_ip  input  DATA_W  store data.
- lsu_rdata_op  output  DATA_W  load data.
- lsu_valid_op  output  1  load data or store ack, one-cycle pulse.
- lsu_stall_op  output  1  LSU must hold.
- mem_req_op  output  1  memory request.
- mem_we_op  output  1  memory write enable.
- mem_be_op  output  DATA_W/8  memory byte enables.
- mem_addr_op  output  ADDR_W  memory address.
- mem_wdata_op  output  DATA_W  memory write data.
- mem_gnt_ip  input  1  memory accepted the request.
- mem_rvalid_ip  input  1  memory response valid; also returned for stores.
- mem_rdata_ip  input  DATA_W  memory read data.
- bus_err_op  output  1  watchdog error pulse.

Behaviour:
- Reset: state IDLE, owner = IF, starve_cnt = 0, discard = 0. All mem_* outputs are 0, both valid outputs 0, bus_err_op 0. Reset asserted mid-transaction abandons the transaction with no valid pulse.
- FSM IDLE:
  - If any request is present, arbitrate.
  - LSU has priority, except that IF wins when starve_cnt == STARVE_LIMIT.
  - Latch the winner's address, we, be and wdata (IF: we = 0, be = all ones, wdata = 0) into registers and record owner.
  - Go to REQ.
- FSM REQ: mem_req_op = 1 and mem_* are driven from the latched registers. On mem_gnt_ip go to RESP. mem_* stay stable until grant.
- FSM RESP: mem_req_op = 0. On mem_rvalid_ip:
  - Drive the owner's rdata from mem_rdata_ip combinationally.
  - Pulse the owner's valid for 1 cycle, suppressed if discard is set.
  - Go to IDLE.
- Minimum latency: request seen in IDLE at cycle 0, grant in cycle 1, rvalid in cycle 2, valid pulse in cycle 2. The next arbitration happens in cycle 3.
- Stalls (combinational): if_stall_op = if_req_ip & ~if_valid_op; lsu_stall_op = lsu_req_ip & ~lsu_valid_op.
- starve_cnt:
  - Increments on each LSU win while if_req_ip = 1.
  - Clears on an IF win or when if_req_ip = 0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Flush:
  - flush_ip while owner = IF in REQ or RESP sets discard. The transaction still completes on the memory side, and the if_valid_op pulse is suppressed. discard clears on return to IDLE.
  - flush_ip in IDLE has no state effect.
  - LSU transactions are never discarded.
- Simultaneous events:
  - A requester dropping its request after it was latched does not abort the transaction.
  - rvalid arriving in REQ is ignored.
  - gnt and rvalid asserted in the same cycle in REQ: treated as gnt only.
- rdata outputs are don't-care when their valid is low; the implementation drives 0.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A wait counter counts cycles spent in REQ and RESP and clears on entry to IDLE.
  - Reaching TIMEOUT_CYCLES pulses bus_err_op for 1 cycle and forces IDLE.
  - The owner's valid pulses in that cycle with rdata = 0xDEADBEEF, unless discard is set.
- MEM_ARB_TIMEOUT_EN undefined: no counter is built, bus_err_op is tied 0, and the arbiter waits indefinitely.

Test Plan:
- IF alone, addr 0x100, gnt at cycle 1, rvalid at cycle 2 with data 0x00500093 -> if_valid_op pulses at cycle 2 with 0x00500093; if_stall_op high in cycles 0-1.
- IF and LSU (load 0x2000) both request in IDLE -> LSU wins; mem_addr_op = 0x2000 first, and the IF transaction issues after the LSU valid pulse.
- LSU requests continuously, IF pending, STARVE_LIMIT = 4 -> after 4 LSU transactions, the 5th arbitration grants IF.
- IF owner, flush_ip pulses in RESP -> rvalid produces no if_valid_op; the next IF request is served normally.
- Store, be = 4'b0011, wdata 0xCAFEBABE -> mem_we_op = 1, mem_be_op = 0011, mem_wdata_op = 0xCAFEBABE held until gnt; lsu_valid_op pulses on rvalid.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, gnt never asserted -> bus_err_op pulses after 8 cycles and lsu_rdata_op = 0xDEADBEEF; without the macro, the arbiter stays in REQ.
